aurora_rx_deframer: RTL

- Sits directly downstream of the Aurora RX path, on the read side of the receive FIFO written by the Aurora data controller.
- Hunts for packet headers, strips header and trailer, forwards payload words on a valid/ready stream with sop/eop, and verifies an XOR checksum.
- Header hunting re-synchronises the stream, so garbage left in the channel or FIFO after a reset is discarded.
- Reports per-packet status and saturating packet/error counters.

---
 rtl/aurora_rx_deframer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/aurora_rx_deframer.sv
// rtl/aurora_rx_deframer.sv - Aurora RX deframer: header hunt, payload forwarding, XOR checksum, status counters
module aurora_rx_deframer #(
  parameter int          MAX_LEN  = 1024,
  parameter logic [15:0] HDR_MARK = 16'hA5A5
) (
  input  logic        user_clk,
  input  logic        rst_n,
  input  logic        channel_up_i,
  input  logic [31:0] fifo_dat_i,
  input  logic        fifo_empty_i,
  output logic        fifo_rd_o,
  output logic [31:0] pkt_dat_o,
  output logic        pkt_vld_o,
  input  logic        pkt_rdy_i,
  output logic        pkt_sop_o,
  output logic        pkt_eop_o,
  output logic        pkt_done_o,
  output logic        pkt_bad_o,
  output logic [15:0] pkt_cnt_o,
  output logic [15:0] err_cnt_o
);

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    TRAILER = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_remaining;
  logic [15:0] w_remaining_nxt;
  logic [15:0] r_len;
  logic [15:0] w_len_nxt;
  logic [31:0] r_csum;
  logic [31:0] w_csum_nxt;
  logic        r_done;
  logic        w_done_nxt;
  logic        r_bad;
  logic        w_bad_nxt;
  logic [15:0] r_pkt_cnt;
  logic [15:0] r_err_cnt;
  logic        w_pkt_inc;
  logic        w_err_inc;
  logic        w_avail;
  logic        w_hdr_ok;

  assign w_avail  = ~fifo_empty_i & channel_up_i;
  assign w_hdr_ok = (fifo_dat_i[31:16] == HDR_MARK) &&
                    (fifo_dat_i[15:0] != 16'd0) &&
                    (fifo_dat_i[15:0] <= MAX_LEN_W);

  // Payload is forwarded straight from the FIFO head with no extra latency.
  assign pkt_dat_o  = fifo_dat_i;
  assign pkt_vld_o  = (r_state == PAYLOAD) & w_avail;
  assign pkt_sop_o  = pkt_vld_o & (r_remaining == r_len);
  assign pkt_eop_o  = pkt_vld_o & (r_remaining == 16'd1);
  assign pkt_done_o = r_done;
  assign pkt_bad_o  = r_bad;
  assign pkt_cnt_o  = r_pkt_cnt;
  assign err_cnt_o  = r_err_cnt;

  always_comb begin
    fifo_rd_o = 1'b0;
    case (r_state)
      HUNT, TRAILER: fifo_rd_o = w_avail;
      PAYLOAD:       fifo_rd_o = pkt_vld_o & pkt_rdy_i;
      default:       fifo_rd_o = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_len_nxt       = r_len;
    w_csum_nxt      = r_csum;
    w_done_nxt      = 1'b0;
    w_bad_nxt       = 1'b0;
    w_pkt_inc       = 1'b0;
    w_err_inc       = 1'b0;
    if (!channel_up_i) begin
      // Losing the channel mid-packet aborts it as a bad packet.
      if (r_state != HUNT) begin
        w_state_nxt = HUNT;
        w_done_nxt  = 1'b1;
        w_bad_nxt   = 1'b1;
        w_pkt_inc   = 1'b1;
        w_err_inc   = 1'b1;
      end
    end else begin
      case (r_state)
        HUNT: begin
          if (fifo_rd_o) begin
            if (w_hdr_ok) begin
              w_remaining_nxt = fifo_dat_i[15:0];
              w_len_nxt       = fifo_dat_i[15:0];
              w_csum_nxt      = 32'd0;
              w_state_nxt     = PAYLOAD;
            end else begin
              w_err_inc = 1'b1;
            end
          end
        end
        PAYLOAD: begin
          if (fifo_rd_o) begin
            w_csum_nxt      = r_csum ^ fifo_dat_i;
            w_remaining_nxt = r_remaining - 16'd1;
            if (r_remaining == 16'd1) begin
              w_state_nxt = TRAILER;
            end
          end
        end
        TRAILER: begin
          if (fifo_rd_o) begin
            w_done_nxt  = 1'b1;
            w_bad_nxt   = (fifo_dat_i != r_csum);
            w_pkt_inc   = 1'b1;
            w_err_inc   = (fifo_dat_i != r_csum);
            w_state_nxt = HUNT;
          end
        end
        default: begin
          w_state_nxt = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge user_clk) begin
    if (!rst_n) begin
      r_state     <= HUNT;
      r_remaining <= 16'd0;
      r_len       <= 16'd0;
      r_csum      <= 32'd0;
      r_done      <= 1'b0;
      r_bad       <= 1'b0;
      r_pkt_cnt   <= 16'd0;
      r_err_cnt   <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_len       <= w_len_nxt;
      r_csum      <= w_csum_nxt;
      r_done      <= w_done_nxt;
      r_bad       <= w_bad_nxt;
      // Each counter saturates on its own, even when both bump together.
      if (w_pkt_inc && (r_pkt_cnt != 16'hFFFF)) begin
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end
      if (w_err_inc && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

endmodule
